// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32/RV64 immediate generator with a two-entry valid/ready skid stage.
// Immediate is extracted at input acceptance; main register drives execute, skid absorbs a stall.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;
  localparam logic [2:0] SRC_Z = 3'b101;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_new;
  logic             ill_new;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_ill;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_ill;

  logic             accept;
  logic             main_free;

  // Opcode bits never contribute to the immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // Every format is built as a 32-bit value whose bit 31 is the correct sign (0 for Z),
  // so widening to XLEN is a single sign-extension.
  always_comb begin
    imm32   = 32'd0;
    ill_new = 1'b0;
    case (imm_src)
      SRC_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      SRC_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SRC_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SRC_U: imm32 = {instr[31:12], 12'd0};
      SRC_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SRC_Z: imm32 = {27'd0, instr[19:15]};
      default: begin
        imm32   = 32'd0;
        ill_new = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm_new = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm_new = imm32;
    end
  endgenerate

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      main_ill   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_ill   <= 1'b0;
    end else if (main_free) begin
      // Skid is older than any new input, and in_ready is low whenever it is full.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_tag   <= skid_tag;
        main_ill   <= skid_ill;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_imm   <= imm_new;
        main_tag   <= in_tag;
        main_ill   <= ill_new;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= imm_new;
      skid_tag   <= in_tag;
      skid_ill   <= ill_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      illegal_cnt <= '0;
    end else if (accept && ill_new && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = main_valid;
  assign imm_ext     = main_imm;
  assign out_tag     = main_tag;
  assign out_illegal = main_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed and scoreboarded checks of imm_gen_pipe at XLEN 32 and 64.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [2:0]  imm_src = 3'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic [1:0]  cnt32;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;
  logic [15:0] cnt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_ext(imm32), .out_tag(tag32), .out_illegal(ill32), .illegal_cnt(cnt32),
    .cnt_clr(cnt_clr)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_ext(imm64), .out_tag(tag64), .out_illegal(ill64), .illegal_cnt(cnt64),
    .cnt_clr(cnt_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] src, input logic [31:0] ins, input logic [4:0] tg);
    in_valid = 1'b1;
    imm_src  = src;
    instr    = ins;
    in_tag   = tg;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] ref_imm(input logic [2:0] src, input logic [31:0] ins);
    longint s, hi, r;
    s = $signed(ins);
    hi = s >>> 31;
    r = 0;
    case (src)
      3'd0: r = s >>> 20;
      3'd1: begin hi = s >>> 25; r = hi << 5; r[4:0] = ins[11:7]; end
      3'd2: begin r = hi << 12; r[11] = ins[7]; r[10:5] = ins[30:25]; r[4:1] = ins[11:8]; end
      3'd3: begin r = s; r[11:0] = 12'd0; end
      3'd4: begin r = hi << 20; r[19:12] = ins[19:12]; r[11] = ins[20]; r[10:1] = ins[30:21]; end
      3'd5: r = longint'(ins[19:15]);
      default: r = 0;
    endcase
    return r;
  endfunction

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } entry_t;

  entry_t      sb[$];
  entry_t      e;
  logic        stalled;
  logic [63:0] held_imm;
  logic [4:0]  held_tag;
  logic        held_ill;
  int          pushed;
  int          cycles;

  initial begin
    step();
    step();
    check("reset_out_valid", out_valid32, 0);
    check("reset_in_ready", in_ready32, 1);
    check("reset_imm", imm32, 0);
    check("reset_tag", tag32, 0);
    check("reset_ill", ill32, 0);
    check("reset_cnt", cnt32, 0);
    rst = 1'b0;
    step();

    // Format extraction, XLEN=32, each result visible right after the accepting edge.
    send(3'd0, 32'hFFF00093, 5'd1);
    check("i_valid", out_valid32, 1);
    check("i_imm", imm32, 32'hFFFFFFFF);
    check("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    check("i_tag", tag32, 5'd1);
    send(3'd0, 32'h07F00093, 5'd2);
    check("i_pos_imm", imm32, 32'h0000007F);
    send(3'd1, 32'hFE20AE23, 5'd3);
    check("s_imm", imm32, 32'hFFFFFFFC);
    send(3'd2, 32'hFE000EE3, 5'd4);
    check("b_neg_imm", imm32, 32'hFFFFFFFC);
    send(3'd2, 32'h00000463, 5'd5);
    check("b_pos_imm", imm32, 32'h00000008);
    send(3'd3, 32'h123450B7, 5'd6);
    check("u_imm", imm32, 32'h12345000);
    send(3'd3, 32'h800000B7, 5'd7);
    check("u_imm64", imm64, 64'hFFFFFFFF80000000);
    check("u_imm32", imm32, 32'h80000000);
    send(3'd4, 32'hFF9FF06F, 5'd8);
    check("j_imm", imm32, 32'hFFFFFFF8);
    send(3'd5, 32'h000F8073, 5'd9);
    check("z_imm", imm32, 32'h0000001F);
    check("z_imm64", imm64, 64'h000000000000001F);
    check("z_ill", ill32, 0);
    step();
    check("drain_idle", out_valid32, 0);

    // Backpressure: two entries fit, the third waits for the skid to drain.
    out_ready = 1'b0;
    send(3'd0, 32'h00100093, 5'd1);
    check("bp_e1_valid", out_valid32, 1);
    check("bp_e1_ready", in_ready32, 1);
    send(3'd0, 32'h00200093, 5'd2);
    check("bp_e2_ready_low", in_ready32, 0);
    check("bp_e2_head", tag32, 5'd1);
    in_valid = 1'b1; imm_src = 3'd0; instr = 32'h00300093; in_tag = 5'd3;
    step();
    check("bp_e3_stall_ready", in_ready32, 0);
    check("bp_hold_tag", tag32, 5'd1);
    check("bp_hold_imm", imm32, 32'h1);
    out_ready = 1'b1;
    step();
    check("bp_out2_tag", tag32, 5'd2);
    check("bp_out2_imm", imm32, 32'h2);
    check("bp_ready_back", in_ready32, 1);
    step();
    in_valid = 1'b0;
    check("bp_out3_tag", tag32, 5'd3);
    check("bp_out3_valid", out_valid32, 1);
    step();
    check("bp_empty", out_valid32, 0);

    // Illegal selects and the saturating counter.
    send(3'd7, 32'hFFFFFFFF, 5'd10);
    check("ill_imm", imm32, 0);
    check("ill_flag", ill32, 1);
    check("ill_cnt1", cnt32, 1);
    for (int i = 0; i < 4; i++) send(3'd6, 32'hFFFFFFFF, 5'd11);
    check("ill_cnt_sat", cnt32, 2'd3);
    check("ill_cnt64", cnt64, 16'd5);
    cnt_clr = 1'b1;
    send(3'd7, 32'h0, 5'd12);
    cnt_clr = 1'b0;
    check("ill_clr_pri", cnt32, 0);
    check("ill_clr_pri64", cnt64, 0);
    send(3'd0, 32'h00100093, 5'd13);
    check("legal_no_cnt", cnt32, 0);
    check("legal_flag", ill32, 0);
    step();

    // Asynchronous reset with both entries occupied.
    send(3'd7, 32'h0, 5'd20);
    out_ready = 1'b0;
    send(3'd0, 32'hFFF00093, 5'd21);
    send(3'd0, 32'hFFF00093, 5'd22);
    check("ar_full", in_ready32, 0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", out_valid32, 0);
    check("ar_ready", in_ready32, 1);
    check("ar_imm", imm32, 0);
    check("ar_tag", tag32, 0);
    check("ar_cnt", cnt32, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("ar_no_stale1", out_valid32, 0);
    step();
    check("ar_no_stale2", out_valid32, 0);

    // Random stream against a scoreboard.
    pushed = 0;
    cycles = 0;
    stalled = 1'b0;
    while (pushed < 10000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 70);
      imm_src   = 3'($urandom_range(0, 7));
      instr     = $urandom;
      in_tag    = 5'($urandom_range(0, 31));
      @(negedge clk);
      if (stalled) begin
        check("rnd_hold_valid", out_valid32, 1);
        check("rnd_hold_imm", imm32, held_imm[31:0]);
        check("rnd_hold_tag", tag32, held_tag);
        check("rnd_hold_ill", ill32, held_ill);
      end
      if (in_valid && in_ready32) begin
        e.imm = ref_imm(imm_src, instr);
        e.tag = in_tag;
        e.ill = (imm_src >= 3'd6);
        sb.push_back(e);
        pushed++;
      end
      if (out_valid32 && out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rnd_imm", imm32, e.imm[31:0]);
          check("rnd_imm64", imm64, e.imm);
          check("rnd_tag", tag32, e.tag);
          check("rnd_ill", ill32, e.ill);
        end
      end
      stalled  = out_valid32 && !out_ready;
      held_imm = imm32;
      held_tag = tag32;
      held_ill = ill32;
      @(posedge clk);
      #1;
      cycles++;
    end
    check("rnd_budget", pushed, 10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid32 && sb.size() != 0) begin
        e = sb.pop_front();
        check("drain_imm", imm32, e.imm[31:0]);
        check("drain_tag", tag32, e.tag);
      end
      step();
    end
    check("sb_empty", sb.size(), 0);
    check("final_idle", out_valid32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

- Parametrised, pipelined immediate generator for the RV32/RV64 decode path.
- Extracts and sign- or zero-extends the immediate for all base formats (I, S, B, U, J) and the CSR 5-bit unsigned immediate, then presents it to execute through a valid/ready skid stage so decode stalls do not lose instructions.
- Flags illegal format selects and keeps a saturating count of them for debug.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- TAG_W, 5, width of the sideband tag (e.g. rd index or ROB id) carried alongside the immediate.
- CNT_W, 16, width of the illegal-select counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction word present.
- in_ready  output  1  block can accept; transfer when in_valid & in_ready.
- instr  input  32  raw instruction word (always 32 bits regardless of XLEN).
- imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR uimm), 110/111 illegal.
- in_tag  input  TAG_W  sideband passed through unchanged.
- out_valid  output  1  imm_ext/out_tag/out_illegal valid.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
- imm_ext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the presented entry.
- out_illegal  output  1  entry was accepted with imm_src 110/111.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal selects.
- cnt_clr  input  1  synchronous clear of illegal_cnt.

## Operation
- Extraction (combinational, at input), sext = replicate bit 31 of instr up to XLEN:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}); for XLEN=64 bits 63:32 copy instr[31].
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z: zero-extend instr[19:15].
  - 110/111: imm_ext = 0, out_illegal = 1.
- Two-entry buffer: main register (drives outputs) plus skid register.
  - in_ready = !skid_valid (a registered value; no combinational path from out_ready).
  - Accept with main empty, or with main draining this cycle and skid empty: write main.
  - Accept while main is held (out_valid & !out_ready): write skid.
  - Main drains while skid is full: main <= skid, skid empties; accept is impossible that cycle because in_ready = 0.
  - Entries leave in acceptance order; never dropped or duplicated.
- illegal_cnt: +1 per accepted illegal entry (counted at input acceptance); saturates at all-ones; cnt_clr has priority over increment in the same cycle.

## Timing
- Reset values: out_valid 0, skid empty, in_ready 1, imm_ext 0, out_tag 0, out_illegal 0, illegal_cnt 0.
- Latency: entry accepted in cycle N is presented at out_valid in cycle N+1 when main is free.
- Throughput: one entry per cycle while out_ready = 1.
- Backpressure: in_ready falls the cycle after the skid fills and rises the cycle after the skid drains into main.
- While out_valid = 1 and out_ready = 0, imm_ext/out_tag/out_illegal are held stable.
- Reset mid-operation: both entries are discarded immediately (asynchronously), outputs return to reset values, and illegal_cnt clears.

## Test plan
- Formats, XLEN=32, out_ready=1:
  - I instr 0xFFF00093 -> 0xFFFFFFFF
  - S 0xFE20AE23 -> 0xFFFFFFFC
  - U 0x123450B7 -> 0x12345000
  - J 0xFF9FF06F -> 0xFFFFFFF8
  - Z with instr[19:15]=11111 -> 0x0000001F
  - Each result appears one cycle after acceptance.
- XLEN=64: U 0x800000B7 -> 0xFFFFFFFF80000000; I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold out_ready=0 and offer 3 tagged entries.
  - Required: entries 1 and 2 are accepted; in_ready is 0 from the cycle after entry 2 is accepted; entry 3 stalls.
  - Release out_ready: tags 1, 2, 3 appear in order on consecutive cycles, with no loss.
- Illegal select: imm_src 111 -> imm_ext 0, out_illegal 1, illegal_cnt 1.
  - With CNT_W=2, after 5 illegal entries illegal_cnt = 3.
  - cnt_clr together with an illegal accept in the same cycle -> illegal_cnt 0.
- Asynchronous reset with both entries full: out_valid 0 and in_ready 1 before the next clock edge; no stale entry is presented after reset is released.
- Random stream of 10k entries with random in_valid and out_ready, checked against a scoreboard: order, values and tags match, and no output changes while stalled.
